enc164_arb: RTL and testbench
=============================

# enc164_arb

Sequential 16-to-4 priority encoder with request latching and a valid/ack handshake. It is the encode direction of the team's 4-to-16 decoder: sixteen one-hot request lines go in, a 4-bit index comes out. Requests are captured into a pending register and served one at a time, lowest index first, until the consumer acknowledges each one. It sits between the lab board's switch and button request sources and any downstream 4-to-16 decoder or 7-segment display stage.

## Interface
- LOW_FIRST, 1, priority direction: 1 means index 0 has the highest priority; 0 means index 15 has the highest priority.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- req  input  16  request lines; a bit sampled high at an edge sets the matching pending bit. Pulses or levels are both accepted.
- ack  input  1  consumer acknowledge; honoured only while valid=1.
- code  output  4  index of the request being served; registered.
- valid  output  1  code is presented and waiting for ack; registered.
- pend  output  16  pending-request register, readable for debug.
- busy  output  1  equals the OR of all pend bits.
- pcnt  output  5  popcount of pend, range 0..16.

## Operation
- Pending register update on every edge, with rst=0:
  - pend <= (pend & ~clr) | req
  - clr is the one-hot of code when valid & ack, and zero otherwise.
- If a req bit and the clear for the same bit occur in the same cycle, req wins and the bit stays set.
- The FSM has two states, IDLE and SERVE.
- IDLE (valid=0):
  - If pend != 0, go to SERVE. code is loaded with the priority encode of the registered pend, using LOW_FIRST.
  - If pend == 0, stay in IDLE and hold code.
- SERVE (valid=1):
  - code is frozen. There is no preemption: a newly arriving higher-priority req does not change code.
  - When ack=1, clear pend[code] and go to IDLE.
  - When ack=0, stay in SERVE.
- ack while in IDLE is ignored and has no effect on pend.
- busy and pcnt are combinational from the registered pend. They reflect the pend value after the most recent edge.
- Arithmetic:
  - pcnt is an unsigned 5-bit sum of 16 one-bit terms, with no overflow; 16 encodes as 5'b10000.
  - code is a plain binary index 0..15.
- Reset: rst=1 at an edge forces the following, overriding any req or ack in the same cycle:
  - pend=16'h0000
  - state=IDLE
  - valid=0
  - code=4'h0
- Reset mid-SERVE drops the grant and all pending requests. The consumer must treat valid falling without ack as an abort.

## Timing
- Request latency:
  - req[i] is sampled high at edge k.
  - pend[i]=1 after edge k.
  - With the FSM in IDLE, valid=1 and code=i after edge k+1.
- Ack latency:
  - ack is sampled high at edge m while valid=1.
  - After edge m: valid=0 and pend[code]=0.
  - The next grant appears after edge m+1 if pend is still non-zero.
- Throughput is at most one grant per 2 cycles; every grant is followed by one IDLE cycle.
- code stays stable from the edge on which valid rises through the edge on which ack is accepted. After that it holds its last value while in IDLE.
- ack held high continuously produces a grant/ack pair every 2 cycles. Each SERVE therefore lasts exactly 1 cycle.
- All outputs are glitch-free registered values, except busy and pcnt, which are single-level combinational logic from pend.

## Test plan
- Reset, then idle:
  - Stimulus: rst=1 for 2 cycles, req=0.
  - Required: pend=0, valid=0, code=0, busy=0, pcnt=0. With ack=1 pulsed while idle, all outputs remain unchanged.
- Single request:
  - Stimulus: one-cycle pulse req=16'h0020 at edge k.
  - Required: after edge k, pend=16'h0020 and pcnt=1. After edge k+1, valid=1 and code=5.
  - Then ack=1 at the next edge. Required: valid=0 and pend=0.
- Priority order:
  - Stimulus: req=16'h8101 for one cycle, with ack held high thereafter.
  - Required with LOW_FIRST=1: codes 0, 8, 15 in successive grants spaced 2 cycles apart, then busy=0.
  - Required with LOW_FIRST=0: codes 15, 8, 0.
- No preemption:
  - Stimulus: req=16'h0400 is granted (code=10, ack=0). Then req=16'h0001 is pulsed.
  - Required: code stays 10 while ack=0. After ack is given, the next grant is code=0.
- Same-cycle re-request:
  - Stimulus: while serving code=3, assert ack=1 and req=16'h0008 on the same edge.
  - Required: pend[3] stays 1, and after one IDLE cycle code=3 is granted again.
- Reset mid-operation:
  - Stimulus: pend=16'hFFFF (pcnt=16), valid=1, code=0. Assert rst=1 together with req=16'h0002.
  - Required after that edge: pend=0, valid=0, code=0, pcnt=0.

Source files
------------

// File: rtl/enc164_arb.sv
// 16-to-4 priority encoder with pending-request latching and a valid/ack
// handshake: one grant at a time, no preemption, one IDLE cycle between grants.
module enc164_arb #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_req,
  input  logic        i_ack,
  output logic [3:0]  o_code,
  output logic        o_valid,
  output logic [15:0] o_pend,
  output logic        o_busy,
  output logic [4:0]  o_pcnt
);

  localparam int unsigned N  = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = 5;

  typedef enum logic {S_IDLE, S_SERVE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_pend;
  logic [CW-1:0] r_code;
  logic          r_valid;

  logic [CW-1:0] w_enc;
  logic [N-1:0]  w_clr;
  logic [PW-1:0] w_cnt;

  // Priority encode of the registered pend; the last match in scan order wins.
  always_comb begin
    w_enc = '0;
    if (LOW_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (r_pend[i]) w_enc = CW'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r_pend[i]) w_enc = CW'(i);
      end
    end
  end

  // Clear only the bit being served, and only on an accepted ack.
  always_comb begin
    w_clr = '0;
    if (r_valid && i_ack) w_clr = N'(1) << r_code;
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_cnt = w_cnt + PW'(r_pend[i]);
    end
  end

  // Pending register and grant FSM; req is OR-ed in after the clear so it wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | i_req;
      case (r_state)
        S_IDLE: begin
          if (|r_pend) begin
            r_state <= S_SERVE;
            r_valid <= 1'b1;
            r_code  <= w_enc;
          end
        end
        S_SERVE: begin
          if (i_ack) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_code  = r_code;
  assign o_valid = r_valid;
  assign o_pend  = r_pend;
  assign o_busy  = |r_pend;
  assign o_pcnt  = w_cnt;

endmodule

// File: tb/tb_enc164_arb.sv
// Bench for enc164_arb: both priority directions side by side, directed
// scenarios plus randomized traffic against a cycle-level reference model.
module tb_enc164_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        ack;

  // index 0: LOW_FIRST=0, index 1: LOW_FIRST=1
  logic [3:0]  code  [2];
  logic        valid [2];
  logic [15:0] pend  [2];
  logic        busy  [2];
  logic [4:0]  pcnt  [2];

  logic [15:0] m_pend  [2];
  logic        m_valid [2];
  logic [3:0]  m_code  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enc164_arb #(.LOW_FIRST(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_ack(ack),
    .o_code(code[0]), .o_valid(valid[0]), .o_pend(pend[0]),
    .o_busy(busy[0]), .o_pcnt(pcnt[0])
  );

  enc164_arb #(.LOW_FIRST(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_ack(ack),
    .o_code(code[1]), .o_valid(valid[1]), .o_pend(pend[1]),
    .o_busy(busy[1]), .o_pcnt(pcnt[1])
  );

  // Winner index from bit arithmetic: isolate lowest set bit, or log of (p+1) for highest.
  function automatic logic [3:0] pick(input logic [15:0] p, input bit low);
    logic [15:0] iso;
    logic [16:0] t;
    if (low) begin
      iso = p & (~p + 16'd1);
      return 4'($clog2(iso));
    end
    t = {1'b0, p} + 17'd1;
    return 4'($clog2(t) - 1);
  endfunction

  // Advance one edge with the currently driven inputs and step the reference model.
  task automatic tick();
    logic [15:0] q = req;
    logic        a = ack;
    logic        r = rst;
    logic [15:0] nxt;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_pend[d] = '0; m_valid[d] = 1'b0; m_code[d] = '0;
      end else begin
        nxt = m_pend[d];
        if (m_valid[d] && a) nxt[m_code[d]] = 1'b0;
        nxt = nxt | q;
        if (!m_valid[d]) begin
          if (m_pend[d] != 0) begin
            m_valid[d] = 1'b1;
            m_code[d]  = pick(m_pend[d], d == 1);
          end
        end else if (a) begin
          m_valid[d] = 1'b0;
        end
        m_pend[d] = nxt;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d] !== 16'h0 || valid[d] !== 1'b0 || code[d] !== 4'h0 ||
          busy[d] !== 1'b0 || pcnt[d] !== 5'd0) begin
        errors++;
        $display("FAIL reset d=%0d: pend=%h valid=%b code=%h busy=%b pcnt=%0d, need all zero",
                 d, pend[d], valid[d], code[d], busy[d], pcnt[d]);
      end
    end
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d] !== 16'h0 || valid[d] !== 1'b0 || code[d] !== 4'h0 || pcnt[d] !== 5'd0) begin
        errors++;
        $display("FAIL idle_ack d=%0d: pend=%h valid=%b code=%h pcnt=%0d, need all zero",
                 d, pend[d], valid[d], code[d], pcnt[d]);
      end
    end
  endtask

  task automatic test_single();
    req = 16'h0020; tick();
    req = '0;
    checks++;
    if (pend[1] !== 16'h0020 || pcnt[1] !== 5'd1 || valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL single_latch: pend=%h pcnt=%0d valid=%b, need 0020 1 0", pend[1], pcnt[1], valid[1]);
    end
    tick();
    checks++;
    if (valid[1] !== 1'b1 || code[1] !== 4'd5) begin
      errors++;
      $display("FAIL single_grant: valid=%b code=%0d, need 1 5", valid[1], code[1]);
    end
    ack = 1'b1; tick();
    ack = 1'b0;
    checks++;
    if (valid[1] !== 1'b0 || pend[1] !== 16'h0 || code[1] !== 4'd5) begin
      errors++;
      $display("FAIL single_ack: valid=%b pend=%h code=%0d, need 0 0000 5", valid[1], pend[1], code[1]);
    end
    tick();
  endtask

  task automatic test_priority();
    logic [3:0] exp_code [2][3];
    int         seen [2];
    exp_code[0][0] = 4'd15; exp_code[0][1] = 4'd8; exp_code[0][2] = 4'd0;
    exp_code[1][0] = 4'd0;  exp_code[1][1] = 4'd8; exp_code[1][2] = 4'd15;
    seen[0] = 0; seen[1] = 0;
    req = 16'h8101; ack = 1'b1; tick();
    req = '0;
    // Grants must land on ticks 1, 3, 5 after the request edge.
    for (int t = 1; t <= 6; t++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ((t % 2) == 1) begin
          if (valid[d] !== 1'b1 || seen[d] > 2 || code[d] !== exp_code[d][seen[d]]) begin
            errors++;
            $display("FAIL prio d=%0d t=%0d: valid=%b code=%0d, need 1 %0d",
                     d, t, valid[d], code[d], exp_code[d][seen[d] > 2 ? 2 : seen[d]]);
          end
          seen[d]++;
        end else if (valid[d] !== 1'b0) begin
          errors++;
          $display("FAIL prio_gap d=%0d t=%0d: valid=%b, need 0", d, t, valid[d]);
        end
      end
    end
    ack = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b0 || pcnt[d] !== 5'd0) begin
        errors++;
        $display("FAIL prio_done d=%0d: busy=%b pcnt=%0d, need 0 0", d, busy[d], pcnt[d]);
      end
    end
    tick();
  endtask

  task automatic test_no_preempt();
    req = 16'h0400; tick();
    req = '0; tick();
    req = 16'h0001; tick();
    req = '0;
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (valid[1] !== 1'b1 || code[1] !== 4'd10) begin
        errors++;
        $display("FAIL no_preempt t=%0d: valid=%b code=%0d, need 1 10", t, valid[1], code[1]);
      end
      tick();
    end
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    checks++;
    if (valid[1] !== 1'b1 || code[1] !== 4'd0 || pend[1] !== 16'h0001) begin
      errors++;
      $display("FAIL next_grant: valid=%b code=%0d pend=%h, need 1 0 0001", valid[1], code[1], pend[1]);
    end
    ack = 1'b1; tick();
    ack = 1'b0; tick();
  endtask

  task automatic test_rerequest();
    req = 16'h0008; tick();
    req = '0; tick();
    checks++;
    if (valid[1] !== 1'b1 || code[1] !== 4'd3) begin
      errors++;
      $display("FAIL rereq_grant: valid=%b code=%0d, need 1 3", valid[1], code[1]);
    end
    ack = 1'b1; req = 16'h0008; tick();
    ack = 1'b0; req = '0;
    checks++;
    if (valid[1] !== 1'b0 || pend[1] !== 16'h0008) begin
      errors++;
      $display("FAIL rereq_keep: valid=%b pend=%h, need 0 0008", valid[1], pend[1]);
    end
    tick();
    checks++;
    if (valid[1] !== 1'b1 || code[1] !== 4'd3) begin
      errors++;
      $display("FAIL rereq_again: valid=%b code=%0d, need 1 3", valid[1], code[1]);
    end
    ack = 1'b1; tick();
    ack = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    req = 16'hFFFF; tick();
    req = '0; tick();
    checks++;
    if (valid[1] !== 1'b1 || code[1] !== 4'd0 || pcnt[1] !== 5'd16 || pend[1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL full_pend: valid=%b code=%0d pcnt=%0d pend=%h, need 1 0 16 ffff",
               valid[1], code[1], pcnt[1], pend[1]);
    end
    rst = 1'b1; req = 16'h0002; tick();
    rst = 1'b0; req = '0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d] !== 16'h0 || valid[d] !== 1'b0 || code[d] !== 4'h0 ||
          pcnt[d] !== 5'd0 || busy[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid d=%0d: pend=%h valid=%b code=%h pcnt=%0d busy=%b, need all zero",
                 d, pend[d], valid[d], code[d], pcnt[d], busy[d]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req = 16'($urandom) & 16'($urandom) & 16'($urandom);
      ack = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (pend[d] !== m_pend[d] || valid[d] !== m_valid[d] || code[d] !== m_code[d] ||
            busy[d] !== (m_pend[d] != 0) || pcnt[d] !== 5'($countones(m_pend[d]))) begin
          errors++;
          $display("FAIL random c=%0d d=%0d: pend=%h valid=%b code=%0d busy=%b pcnt=%0d, need %h %b %0d %b %0d",
                   c, d, pend[d], valid[d], code[d], busy[d], pcnt[d],
                   m_pend[d], m_valid[d], m_code[d], m_pend[d] != 0, $countones(m_pend[d]));
        end
      end
    end
    rst = 1'b0; req = '0; ack = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; ack = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_rerequest();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
